// File: rtl/cube_frame_loader.sv
// cube_frame_loader: front end of the cube-solving network.
// Collects a byte-serial cube frame, launches the network with a one-cycle
// load pulse, waits for the network result (with a watchdog), hands the move
// index to the consumer, then clears the network for the next frame.

module cube_frame_loader #(
    parameter int FRAME_BYTES = 15,
    parameter int TIMEOUT     = 4096,
    parameter int CLR_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    output logic                       net_load,
    output logic [8*FRAME_BYTES-1:0]   net_d,
    input  logic                       net_valid,
    input  logic [3:0]                 net_q,
    output logic                       net_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_q,
    output logic                       out_err,
    output logic                       busy
);

    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_LAUNCH,
        S_WAIT,
        S_RESULT,
        S_CLEAR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WD_W-1:0]  wd;
    logic [CLR_W-1:0] clr_cnt;
    logic             ready_en;   // keeps in_ready low until the first edge after reset
    logic             accept;
    logic             capture;
    logic             expire;

    assign accept = in_valid & in_ready;
    assign busy   = (state != S_IDLE);

    // State register and the post-reset ready enable.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    // Next-state decode and state-decoded outputs.
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        net_load  = 1'b0;
        net_clr   = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = ready_en;
                if (in_valid && ready_en) begin
                    state_nxt = (FRAME_BYTES == 1) ? S_LAUNCH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (count == LAST_IDX)) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                net_load  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A network result on the watchdog's final cycle still wins.
                if (net_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_RESULT;
                end else if (wd == WD_LAST) begin
                    expire    = 1'b1;
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                net_clr = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: frame assembly, watchdog, clear counter and result capture.
    // NOTE: the frame register is reset too, so a frame cut short by reset
    // never leaks old bytes onto net_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            wd      <= '0;
            clr_cnt <= '0;
            net_d   <= '0;
            out_q   <= 4'h0;
            out_err <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < FRAME_BYTES; k++) begin
                    if (count == CNT_W'(k)) begin
                        net_d[8*k +: 8] <= in_data;
                    end
                end
                count <= count + 1'b1;
            end

            if (state == S_LAUNCH) begin
                count <= '0;
                wd    <= '0;
            end

            if (state == S_WAIT) begin
                wd <= wd + 1'b1;
            end

            if (capture) begin
                out_q   <= net_q;
                out_err <= 1'b0;
            end

            if (expire) begin
                out_q   <= 4'hF;
                out_err <= 1'b1;
            end

            if (state == S_RESULT) begin
                clr_cnt <= '0;
            end

            if (state == S_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cube_frame_loader.sv
// Testbench for cube_frame_loader. Two instances: one with the default
// watchdog, one with a short watchdog for the timeout scenarios. A select bit
// routes the shared stimulus to one of them; the other sits idle.

module tb_cube_frame_loader;

    localparam int FB       = 15;
    localparam int TO_MAIN  = 4096;
    localparam int TO_SHORT = 16;
    localparam int CLR_N    = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         net_valid;
    logic [3:0]   net_q;
    logic         out_ready;
    logic         sel_t;

    logic         in_ready_m, net_load_m, net_clr_m, out_valid_m, out_err_m, busy_m;
    logic [119:0] net_d_m;
    logic [3:0]   out_q_m;
    logic         in_ready_t, net_load_t, net_clr_t, out_valid_t, out_err_t, busy_t;
    logic [119:0] net_d_t;
    logic [3:0]   out_q_t;

    logic         obs_in_ready, obs_load, obs_clr, obs_out_valid, obs_out_err, obs_busy;
    logic [119:0] obs_net_d;
    logic [3:0]   obs_out_q;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           acc_edge;
    int           load_count;
    int           net_latency;
    logic [3:0]   net_result;
    logic [7:0]   frame [FB];

    cube_frame_loader #(.FRAME_BYTES(FB), .TIMEOUT(TO_MAIN), .CLR_CYCLES(CLR_N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel_t), .in_ready(in_ready_m), .in_data(in_data),
        .net_load(net_load_m), .net_d(net_d_m), .net_valid(net_valid), .net_q(net_q),
        .net_clr(net_clr_m), .out_valid(out_valid_m), .out_ready(out_ready & ~sel_t),
        .out_q(out_q_m), .out_err(out_err_m), .busy(busy_m)
    );

    cube_frame_loader #(.FRAME_BYTES(FB), .TIMEOUT(TO_SHORT), .CLR_CYCLES(CLR_N)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel_t), .in_ready(in_ready_t), .in_data(in_data),
        .net_load(net_load_t), .net_d(net_d_t), .net_valid(net_valid), .net_q(net_q),
        .net_clr(net_clr_t), .out_valid(out_valid_t), .out_ready(out_ready & sel_t),
        .out_q(out_q_t), .out_err(out_err_t), .busy(busy_t)
    );

    assign obs_in_ready  = sel_t ? in_ready_t  : in_ready_m;
    assign obs_load      = sel_t ? net_load_t  : net_load_m;
    assign obs_clr       = sel_t ? net_clr_t   : net_clr_m;
    assign obs_out_valid = sel_t ? out_valid_t : out_valid_m;
    assign obs_out_err   = sel_t ? out_err_t   : out_err_m;
    assign obs_busy      = sel_t ? busy_t      : busy_m;
    assign obs_net_d     = sel_t ? net_d_t     : net_d_m;
    assign obs_out_q     = sel_t ? out_q_t     : out_q_m;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count net_load cycles seen by the network.
    always @(negedge clk) if (obs_load) load_count++;

    // Network model: after a load, raise net_valid net_latency cycles into WAIT
    // (negative latency = never) and hold it until the network is cleared.
    int  ncnt;
    bit  narmed;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net_valid <= 1'b0;
            net_q     <= 4'h0;
            narmed    <= 1'b0;
            ncnt      <= 0;
        end else if (obs_clr) begin
            net_valid <= 1'b0;
            narmed    <= 1'b0;
        end else if (obs_load) begin
            narmed <= 1'b1;
            ncnt   <= 0;
        end else if (narmed) begin
            ncnt <= ncnt + 1;
            if (ncnt + 1 == net_latency) begin
                net_valid <= 1'b1;
                net_q     <= net_result;
                narmed    <= 1'b0;
            end
        end
    end

    // Send the first nbytes of frame[]; called and returns at a negedge.
    task automatic send_frame(input int nbytes, input bit gaps, output bit ok);
        bit acc;
        int n;
        ok = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame[k];
            n = 0;
            while (1) begin
                acc = obs_in_ready;
                @(posedge clk);
                if (acc) break;
                @(negedge clk);
                n++;
                if (n > 50) begin
                    ok = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            acc_edge = cyc;
            if (!ok) return;
        end
    endtask

    // One full transaction, checked against the expected behaviour derived
    // from the frame contents, network latency and watchdog length.
    task automatic run_frame(input string tag, input bit gaps, input int latency,
                             input logic [3:0] res, input int hold, input bit poke);
        logic [119:0] exp_d;
        logic [3:0]   exp_q;
        logic         exp_err;
        int           to_len, w_edge, exp_ov, n;
        bit           ok, poke_bad;

        to_len      = sel_t ? TO_SHORT : TO_MAIN;
        net_latency = latency;
        net_result  = res;
        load_count  = 0;
        for (int k = 0; k < FB; k++) exp_d[8*k +: 8] = frame[k];

        send_frame(FB, gaps, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s accept_timeout: byte not accepted within bound", tag);
            return;
        end

        // Load pulse is visible in the cycle right after the last accept.
        checks++;
        if (obs_load !== 1'b1) begin
            errors++;
            $display("FAIL %s load_latency: net_load=%b want 1 after last accept", tag, obs_load);
        end
        checks++;
        if (obs_net_d !== exp_d) begin
            errors++;
            $display("FAIL %s net_d: got %h want %h", tag, obs_net_d, exp_d);
        end
        w_edge = cyc + 1;

        if (latency >= 0 && latency <= to_len - 1) begin
            exp_ov = w_edge + latency + 1;  exp_q = res;   exp_err = 1'b0;
        end else begin
            exp_ov = w_edge + to_len;       exp_q = 4'hF;  exp_err = 1'b1;
        end

        n = 0;
        poke_bad = 1'b0;
        while (!obs_out_valid && n < 200) begin
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 8'hEE;
                if (obs_in_ready !== 1'b0) poke_bad = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (poke) begin
            checks++;
            if (poke_bad) begin
                errors++;
                $display("FAIL %s extra_byte: in_ready=1 want 0 while busy", tag);
            end
        end

        checks++;
        if (!obs_out_valid) begin
            errors++;
            $display("FAIL %s out_valid_timeout: out_valid=0 want 1", tag);
            return;
        end
        checks++;
        if (cyc !== exp_ov) begin
            errors++;
            $display("FAIL %s result_latency: edge %0d want %0d", tag, cyc, exp_ov);
        end
        checks++;
        if (obs_out_q !== exp_q || obs_out_err !== exp_err) begin
            errors++;
            $display("FAIL %s result: q=%h err=%b want q=%h err=%b",
                     tag, obs_out_q, obs_out_err, exp_q, exp_err);
        end
        checks++;
        if (load_count !== 1 || obs_net_d !== exp_d) begin
            errors++;
            $display("FAIL %s load_once: loads=%0d want 1, net_d=%h want %h",
                     tag, load_count, obs_net_d, exp_d);
        end

        // Output backpressure: result must hold steady.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (obs_out_valid !== 1'b1 || obs_out_q !== exp_q || obs_out_err !== exp_err) begin
                errors++;
                $display("FAIL %s hold_stable[%0d]: v=%b q=%h err=%b want v=1 q=%h err=%b",
                         tag, i, obs_out_valid, obs_out_q, obs_out_err, exp_q, exp_err);
            end
        end

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (obs_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid_drop: got %b want 0", tag, obs_out_valid);
        end

        n = 0;
        while (obs_clr && n < 10) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== CLR_N) begin
            errors++;
            $display("FAIL %s clr_len: net_clr cycles %0d want %0d", tag, n, CLR_N);
        end
        checks++;
        if (obs_in_ready !== 1'b1 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s back_idle: in_ready=%b busy=%b want 1 0", tag, obs_in_ready, obs_busy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({obs_in_ready, obs_load, obs_clr, obs_out_valid, obs_out_err, obs_busy} !== 6'b0 ||
            obs_net_d !== 120'h0 || obs_out_q !== 4'h0) begin
            errors++;
            $display("FAIL %s reset_outputs: rdy=%b load=%b clr=%b v=%b err=%b busy=%b q=%h d=%h want all 0",
                     tag, obs_in_ready, obs_load, obs_clr, obs_out_valid, obs_out_err,
                     obs_busy, obs_out_q, obs_net_d);
        end
    endtask

    task automatic random_frame();
        for (int k = 0; k < FB; k++) frame[k] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sel_t = 1'b0; check_all_zero("reset_main");
        sel_t = 1'b1; check_all_zero("reset_short");
        sel_t = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: in_ready=%b want 0 before first edge", obs_in_ready);
        end
        @(negedge clk);
        checks++;
        if (obs_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: in_ready=%b want 1", obs_in_ready);
        end
    endtask

    task automatic test_normal();
        for (int k = 0; k < FB; k++) frame[k] = 8'(k + 1);
        run_frame("normal", 1'b0, 50, 4'h7, 0, 1'b0);
    endtask

    task automatic test_gaps();
        for (int k = 0; k < FB; k++) frame[k] = 8'(k + 1);
        run_frame("gaps_fixed", 1'b1, 50, 4'h7, 0, 1'b1);
        random_frame();
        run_frame("gaps_rand", 1'b1, int'($urandom_range(5, 60)), 4'($urandom), 3, 1'b1);
    endtask

    task automatic test_timeout();
        sel_t = 1'b1;
        random_frame();
        run_frame("timeout_never", 1'b0, -1, 4'h2, 0, 1'b0);
        random_frame();
        run_frame("timeout_last_cycle", 1'b1, TO_SHORT - 1, 4'h5, 0, 1'b0);
        random_frame();
        run_frame("timeout_just_late", 1'b0, TO_SHORT, 4'h9, 2, 1'b0);
        sel_t = 1'b0;
    endtask

    task automatic test_backpressure();
        random_frame();
        run_frame("out_backpressure", 1'b0, 30, 4'hC, 20, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        random_frame();
        send_frame(7, 1'b1, ok);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        random_frame();
        run_frame("after_reset", 1'b0, 40, 4'h4, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        random_frame();
        run_frame("b2b_first", 1'b0, 25, 4'h3, int'($urandom_range(0, 4)), 1'b0);
        random_frame();
        run_frame("b2b_second", 1'b0, 25, 4'hA, int'($urandom_range(0, 4)), 1'b0);
        for (int i = 0; i < 3; i++) begin
            random_frame();
            run_frame("b2b_rand", 1'(i & 1), int'($urandom_range(1, 80)), 4'($urandom),
                      int'($urandom_range(0, 6)), 1'b0);
        end
    endtask

    initial begin
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        sel_t       = 1'b0;
        net_latency = -1;
        net_result  = 4'h0;
        test_reset();
        test_normal();
        test_gaps();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

endmodule
